hazard_forward_ctrl: RTL and testbench

- Pipeline control block for the 5-stage MIPS datapath.
- Generates the select inputs of the 2:1/3:1 operand muxes in EX, plus the load-use stall and the bubble controls.
- Shadows the destination/write-enable info of in-flight instructions in internal EX/MEM/WB tracking registers.
- Decides forwarding and stalls from that state and the instruction currently in ID.

---
 rtl/hazard_forward_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard / forwarding control for the 5-stage MIPS pipeline.
// Shadows the register-usage info of the instructions in EX, MEM and WB. From
// that state it selects the EX operand-mux inputs. From the same state and the
// instruction now in ID it raises the load-use stall and the bubble request.
// Ports:
//   Clk, Rst_n         clock (rising edge) and asynchronous active-low reset
//   id_*               decoded fields of the instruction currently in ID
//   flush              taken branch/jump resolved in EX; kill the ID instruction
//   fwd_a_sel/b_sel    00 regfile, 01 WB result, 10 MEM ALU result
//   stall              load-use hazard this cycle
//   pc_write           PC enable (~stall)
//   ifid_write         IF/ID enable (~stall)
//   bubble             zero the ID/EX control fields this edge (stall | flush)
// The outputs are combinational, so they are valid in the same cycle as the
// ID inputs.
module hazard_forward_ctrl #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  bubble
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic                  memread;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t id_entry;
    logic   ex_load;

    // A stage can forward only when it really writes a register other than $0.
    function automatic logic is_producer(input stage_t s);
        return s.valid & s.regwrite & (s.dst != '0);
    endfunction

    // MEM wins over WB. A load in MEM never forwards because the load-use stall
    // has already moved it to WB. The WB match does not look at the uses flag;
    // that flag gates only the MEM match.
    function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem,
                                           input stage_t wb, input logic uses,
                                           input logic [REG_ADDR_W-1:0] src);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex.valid) begin
            if (uses && is_producer(mem) && !mem.memread && mem.dst == src) begin
                sel = SEL_MEM;
            end else if (is_producer(wb) && wb.dst == src) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // Collect the ID fields into a single stage record.
    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.rs       = id_rs;
        id_entry.rt       = id_rt;
        id_entry.uses_rs  = id_uses_rs;
        id_entry.uses_rt  = id_uses_rt;
        id_entry.dst      = id_dst;
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
    end

    // Hazard detection and forwarding selects. Flush suppresses the stall.
    always_comb begin
        fwd_a_sel  = SEL_RF;
        fwd_b_sel  = SEL_RF;
        stall      = 1'b0;
        fwd_a_sel  = fwd_sel(ex_q, mem_q, wb_q, ex_q.uses_rs, ex_q.rs);
        fwd_b_sel  = fwd_sel(ex_q, mem_q, wb_q, ex_q.uses_rt, ex_q.rt);
        stall      = id_valid & ~flush & ex_q.memread & is_producer(ex_q)
                   & ((id_uses_rs & (id_rs == ex_q.dst))
                    | (id_uses_rt & (id_rt == ex_q.dst)));
        pc_write   = ~stall;
        ifid_write = ~stall;
        bubble     = stall | flush;
    end

    assign ex_load = id_valid & ~stall & ~flush;

    // Tracking pipeline. A stalled or flushed slot enters EX as an all-zero bubble.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_load ? id_entry : '0;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios with literal
// expectations, then randomized traffic against an age-ordered reference model.
module tb_hazard_forward_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } instr_t;

    logic       Clk;
    logic       Rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, pc_write, ifid_write, bubble;

    int tests = 0;
    int fails = 0;

    hazard_forward_ctrl #(.REG_ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
        .pc_write(pc_write), .ifid_write(ifid_write), .bubble(bubble)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    // hist[0] is the youngest issued instruction (in EX), hist[2] the oldest (in WB).
    instr_t     hist [3];
    instr_t     cur_id;
    logic [1:0] m_fa, m_fb;
    logic       m_stall;

    function automatic logic writes_reg(input instr_t i);
        return i.v && i.rw && (i.dst != 5'd0);
    endfunction

    // The nearest older instruction supplies the operand. A load one ahead cannot
    // supply it (that case stalls), and the uses flag qualifies only that
    // nearest match.
    function automatic logic [1:0] exp_sel(input instr_t ex, input instr_t older1,
                                           input instr_t older2, input logic uses,
                                           input logic [4:0] src);
        if (!ex.v) return 2'd0;
        if (uses && writes_reg(older1) && !older1.mr && older1.dst == src) return 2'd2;
        if (writes_reg(older2) && older2.dst == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic exp_stall(input instr_t id, input logic fl, input instr_t ex);
        logic dep;
        dep = (id.urs && id.rs == ex.dst) || (id.urt && id.rt == ex.dst);
        return id.v && !fl && ex.mr && writes_reg(ex) && dep;
    endfunction

    always_comb begin
        cur_id  = {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
                   id_regwrite, id_memread};
        m_fa    = exp_sel(hist[0], hist[1], hist[2], hist[0].urs, hist[0].rs);
        m_fb    = exp_sel(hist[0], hist[1], hist[2], hist[0].urt, hist[0].rt);
        m_stall = exp_stall(cur_id, flush, hist[0]);
    end

    // Advance the model by one instruction slot per clock edge.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
        end else begin
            hist[0] <= (cur_id.v && !m_stall && !flush) ? cur_id : '0;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every cycle, compare the DUT with the model away from the active edge.
    always @(negedge Clk) begin
        chk("cmp_fwd_a", fwd_a_sel, m_fa);
        chk("cmp_fwd_b", fwd_b_sel, m_fb);
        chk("cmp_stall", {1'b0, stall}, {1'b0, m_stall});
        chk("cmp_pc_write", {1'b0, pc_write}, {1'b0, ~m_stall});
        chk("cmp_ifid_write", {1'b0, ifid_write}, {1'b0, ~m_stall});
        chk("cmp_bubble", {1'b0, bubble}, {1'b0, m_stall | flush});
    end

    // Compare the DUT and the model with hand-computed values at the next negedge.
    task automatic lit(input string name, input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic bub);
        @(negedge Clk);
        chk({name, "_fwd_a"}, fwd_a_sel, fa);
        chk({name, "_fwd_b"}, fwd_b_sel, fb);
        chk({name, "_stall"}, {1'b0, stall}, {1'b0, st});
        chk({name, "_pc_write"}, {1'b0, pc_write}, {1'b0, ~st});
        chk({name, "_ifid_write"}, {1'b0, ifid_write}, {1'b0, ~st});
        chk({name, "_bubble"}, {1'b0, bubble}, {1'b0, bub});
        chk({name, "_model_fwd_a"}, m_fa, fa);
        chk({name, "_model_fwd_b"}, m_fb, fb);
        chk({name, "_model_stall"}, {1'b0, m_stall}, {1'b0, st});
    endtask

    task automatic set_id(input instr_t i, input logic fl);
        id_valid    = i.v;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_uses_rs  = i.urs;
        id_uses_rt  = i.urt;
        id_dst      = i.dst;
        id_regwrite = i.rw;
        id_memread  = i.mr;
        flush       = fl;
    endtask

    task automatic drive(input instr_t i, input logic fl);
        @(posedge Clk);
        #1;
        set_id(i, fl);
    endtask

    function automatic instr_t mk(input logic v, input int rs, input int rt,
                                  input logic urs, input logic urt, input int dst,
                                  input logic rw, input logic mr);
        instr_t r;
        r = {v, 5'(rs), 5'(rt), urs, urt, 5'(dst), rw, mr};
        return r;
    endfunction

    task automatic drain();
        for (int k = 0; k < 3; k++) drive('0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t nop, lw8, add_dep, add8, sub98, and10, lw0, use0, r;
        nop     = '0;
        lw8     = mk(1, 1, 0, 1, 0, 8, 1, 1);
        add_dep = mk(1, 8, 1, 1, 1, 9, 1, 0);
        add8    = mk(1, 1, 2, 1, 1, 8, 1, 0);
        sub98   = mk(1, 8, 8, 1, 1, 9, 1, 0);
        and10   = mk(1, 8, 0, 1, 1, 10, 1, 0);
        lw0     = mk(1, 1, 0, 1, 0, 0, 1, 1);
        use0    = mk(1, 0, 0, 1, 1, 11, 1, 0);

        // Reset held with a load in ID.
        Rst_n = 1'b0;
        set_id(lw8, 1'b0);
        lit("reset", 2'd0, 2'd0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("reset_bubble_eq_flush", {1'b0, bubble}, 2'd1);
        flush = 1'b0;
        drive(lw8, 1'b0);
        Rst_n = 1'b1;
        lit("after_reset", 2'd0, 2'd0, 1'b0, 1'b0);

        // Load-use: a single stall cycle, then the add forwards from WB.
        drive(add_dep, 1'b0);
        lit("loaduse_stall", 2'd0, 2'd0, 1'b1, 1'b1);
        drive(add_dep, 1'b0);
        lit("loaduse_release", 2'd0, 2'd0, 1'b0, 1'b0);
        drive(nop, 1'b0);
        lit("loaduse_fwd", 2'd1, 2'd0, 1'b0, 1'b0);
        drain();

        // ALU chain forwards both operands from MEM.
        drive(add8, 1'b0);
        drive(sub98, 1'b0);
        drive(nop, 1'b0);
        lit("alu_chain", 2'd2, 2'd2, 1'b0, 1'b0);
        drain();

        // Double producer: MEM wins; rt=$0 never forwards.
        drive(add8, 1'b0);
        drive(add8, 1'b0);
        drive(and10, 1'b0);
        drive(nop, 1'b0);
        lit("double_prod", 2'd2, 2'd0, 1'b0, 1'b0);
        drain();

        // A $0 destination causes neither stall nor forwarding.
        drive(lw0, 1'b0);
        drive(use0, 1'b0);
        lit("zero_dst_id", 2'd0, 2'd0, 1'b0, 1'b0);
        drive(nop, 1'b0);
        lit("zero_dst_ex", 2'd0, 2'd0, 1'b0, 1'b0);
        drain();

        // Flush beats stall.
        drive(lw8, 1'b0);
        drive(add_dep, 1'b1);
        lit("flush_vs_stall", 2'd0, 2'd0, 1'b0, 1'b1);
        drive(nop, 1'b0);
        lit("flush_next", 2'd0, 2'd0, 1'b0, 1'b0);
        drain();

        // Random traffic over a few registers, with occasional async reset pulses.
        for (int n = 0; n < 3000; n++) begin
            r.v   = ($urandom_range(0, 7) != 0);
            r.rs  = 5'($urandom_range(0, 3));
            r.rt  = 5'($urandom_range(0, 3));
            r.urs = 1'($urandom_range(0, 1));
            r.urt = 1'($urandom_range(0, 1));
            r.dst = 5'($urandom_range(0, 3));
            r.rw  = ($urandom_range(0, 4) != 0);
            r.mr  = ($urandom_range(0, 2) == 0);
            drive(r, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 199) == 0) begin
                #2 Rst_n = 1'b0;
                #1 Rst_n = 1'b1;
            end
        end

        @(negedge Clk);
        @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
